pulse_group_counter: RTL and testbench

//  Counts accepted laser trigger pulses for one accumulation group. Output pulse_counts

---
 rtl/pulse_group_pkg.sv | 11 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/pulse_group_counter.sv | 117 +++++++++++
 tb/tb_pulse_group_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_group_pkg.sv
// Shared definitions for the pulse group counter: FSM state encoding and default widths.
package pulse_group_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_COUNTING = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level input and produces a registered one-cycle
// pulse on each synchronised rising edge.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            // Registered so the edge reaches the consumer as a clean flop output.
            rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/pulse_group_counter.sv
// Counts accepted laser trigger pulses for one accumulation group, with re-trigger
// hold-off, overrun flagging and group-completion signalling.
//
//  state       | meaning
//  ------------+--------------------------------------------------
//  ST_IDLE     | no group armed, triggers ignored
//  ST_ARMED    | group armed, waiting for the first accepted edge
//  ST_COUNTING | at least one pulse counted, target not reached
//  ST_DONE     | target reached, count frozen until next start
module pulse_group_counter
    import pulse_group_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             capture_en,
    input  logic             start,
    input  logic [CNT_W-1:0] pulses_per_group,
    output logic [CNT_W-1:0] pulse_counts,
    output logic             pulse_strobe,
    output logic             busy,
    output logic             group_done,
    output logic             trig_overrun
);

    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] target, target_next;
    logic [CNT_W-1:0] count_next, count_inc;
    logic [HO_W-1:0]  holdoff_cnt, holdoff_next;
    logic             strobe_next, done_next, overrun_next, busy_next;
    logic             trig_edge, in_group, start_go, accept, reject;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (trig_in),
        .rise_pulse (trig_edge)
    );

    assign in_group  = (state == ST_ARMED) || (state == ST_COUNTING);
    assign start_go  = start && (pulses_per_group != '0);
    // A valid start takes priority and swallows a coincident edge.
    assign accept    = trig_edge && capture_en && (holdoff_cnt == '0) && in_group && !start_go;
    assign reject    = trig_edge && capture_en && (holdoff_cnt != '0) && in_group && !start_go;
    assign count_inc = pulse_counts + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_go) begin
            state_next = ST_ARMED;
        end else if (accept) begin
            state_next = (count_inc == target) ? ST_DONE : ST_COUNTING;
        end
    end

    always_comb begin
        target_next  = target;
        count_next   = pulse_counts;
        strobe_next  = 1'b0;
        done_next    = 1'b0;
        overrun_next = trig_overrun;
        holdoff_next = holdoff_cnt;
        busy_next    = (state_next == ST_ARMED) || (state_next == ST_COUNTING);

        if (holdoff_cnt != '0) begin
            holdoff_next = holdoff_cnt - HO_W'(1);
        end

        if (start_go) begin
            target_next  = pulses_per_group;
            count_next   = '0;
            overrun_next = 1'b0;
        end else if (accept) begin
            count_next   = count_inc;
            strobe_next  = 1'b1;
            done_next    = (count_inc == target);
            holdoff_next = HO_W'(HOLDOFF - 1);
        end else if (reject) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target       <= '0;
            pulse_counts <= '0;
            pulse_strobe <= 1'b0;
            group_done   <= 1'b0;
            trig_overrun <= 1'b0;
            busy         <= 1'b0;
            holdoff_cnt  <= '0;
        end else begin
            target       <= target_next;
            pulse_counts <= count_next;
            pulse_strobe <= strobe_next;
            group_done   <= done_next;
            trig_overrun <= overrun_next;
            busy         <= busy_next;
            holdoff_cnt  <= holdoff_next;
        end
    end

endmodule

// File: tb/tb_pulse_group_counter.sv
// Scoreboard bench for pulse_group_counter: expected counts are queued as triggers
// are driven and checked whenever the DUT strobes.
module tb_pulse_group_counter;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trig_in = 1'b0;
    logic             capture_en = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] pulses_per_group = '0;
    logic [CNT_W-1:0] pulse_counts;
    logic             pulse_strobe, busy, group_done, trig_overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int done_seen = 0;
    int strobe_seen = 0;
    int exp_q[$];

    pulse_group_counter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .HOLDOFF(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trig_in          (trig_in),
        .capture_en       (capture_en),
        .start            (start),
        .pulses_per_group (pulses_per_group),
        .pulse_counts     (pulse_counts),
        .pulse_strobe     (pulse_strobe),
        .busy             (busy),
        .group_done       (group_done),
        .trig_overrun     (trig_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && pulse_strobe) begin
            strobe_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL strobe_unexpected: pulse_counts=%0d, no strobe expected", pulse_counts);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (pulse_counts !== CNT_W'(e)) begin
                    tests_failed++;
                    $display("FAIL strobe_count: got %0d expected %0d", pulse_counts, e);
                end
            end
        end
        if (rst_n && group_done) begin
            done_seen++;
            tests_run++;
            if (pulse_strobe !== 1'b1) begin
                tests_failed++;
                $display("FAIL done_strobe_align: pulse_strobe=%b expected 1", pulse_strobe);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_start(input int ppg);
        @(posedge clk);
        #2 start = 1'b1;
        pulses_per_group = CNT_W'(ppg);
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    // Trigger high for three clocks; gap counts from the rising edge of trig_in.
    task automatic fire(input bit counted, input int exp_val, input int gap);
        if (counted) exp_q.push_back(exp_val);
        @(posedge clk);
        #2 trig_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 trig_in = 1'b0;
        repeat (gap - 4) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        chk("reset_counts", int'(pulse_counts), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(group_done), 0);
        chk("reset_overrun", int'(trig_overrun), 0);
        chk("reset_strobe", int'(pulse_strobe), 0);
        do_reset();
    endtask

    task automatic test_basic();
        int d0, s0;
        d0 = done_seen; s0 = strobe_seen;
        capture_en = 1'b1;
        do_start(4);
        #1 chk("basic_start_busy", int'(busy), 1);
        chk("basic_start_count", int'(pulse_counts), 0);
        for (int i = 1; i <= 4; i++) fire(1, i, 100);
        chk("basic_strobes", strobe_seen - s0, 4);
        chk("basic_done_once", done_seen - d0, 1);
        chk("basic_final_count", int'(pulse_counts), 4);
        chk("basic_busy_after", int'(busy), 0);
        chk("basic_overrun", int'(trig_overrun), 0);
        chk("basic_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_holdoff();
        do_start(3);
        fire(1, 1, 20);
        fire(0, 0, 80);
        chk("holdoff_overrun", int'(trig_overrun), 1);
        chk("holdoff_count", int'(pulse_counts), 1);
        fire(1, 2, 100);
        chk("holdoff_later_count", int'(pulse_counts), 2);
        chk("holdoff_busy", int'(busy), 1);
    endtask

    task automatic test_saturate();
        int d0;
        d0 = done_seen;
        do_start(2);
        #1 chk("sat_overrun_cleared", int'(trig_overrun), 0);
        fire(1, 1, 100);
        fire(1, 2, 100);
        for (int i = 0; i < 3; i++) fire(0, 0, 100);
        chk("sat_count", int'(pulse_counts), 2);
        chk("sat_done_once", done_seen - d0, 1);
        chk("sat_overrun", int'(trig_overrun), 0);
        chk("sat_busy", int'(busy), 0);
    endtask

    task automatic test_restart_coincident();
        do_start(8);
        for (int i = 1; i <= 3; i++) fire(1, i, 100);
        chk("restart_pre_count", int'(pulse_counts), 3);
        @(posedge clk);
        #2 trig_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 start = 1'b1;
        pulses_per_group = CNT_W'(8);
        @(posedge clk);
        #2 start = 1'b0;
        #1 chk("restart_count", int'(pulse_counts), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_state", int'(dut.state), 1);
        trig_in = 1'b0;
        repeat (100) @(posedge clk);
        fire(1, 1, 100);
        chk("restart_next_count", int'(pulse_counts), 1);
    endtask

    task automatic test_capture_gate();
        do_start(5);
        capture_en = 1'b0;
        for (int i = 0; i < 3; i++) fire(0, 0, 100);
        chk("gate_off_count", int'(pulse_counts), 0);
        capture_en = 1'b1;
        fire(1, 1, 100);
        fire(1, 2, 100);
        chk("gate_count", int'(pulse_counts), 2);
        chk("gate_busy", int'(busy), 1);
        chk("gate_overrun", int'(trig_overrun), 0);
        do_start(0);
        #1 chk("zero_ppg_busy_hold", int'(pulse_counts), 2);
        do_reset();
        do_start(0);
        #1 chk("zero_ppg_idle_busy", int'(busy), 0);
        chk("zero_ppg_idle_state", int'(dut.state), 0);
        fire(0, 0, 100);
        chk("zero_ppg_count", int'(pulse_counts), 0);
    endtask

    task automatic test_async_reset();
        do_start(5);
        fire(1, 1, 100);
        fire(1, 2, 100);
        chk("arst_pre_count", int'(pulse_counts), 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(pulse_counts), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_overrun", int'(trig_overrun), 0);
        chk("arst_done", int'(group_done), 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        fire(0, 0, 100);
        chk("arst_idle_busy", int'(busy), 0);
        chk("arst_idle_count", int'(pulse_counts), 0);
    endtask

    task automatic test_latency();
        do_start(3);
        repeat (100) @(posedge clk);
        exp_q.push_back(1);
        @(posedge clk);
        #2 trig_in = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1 chk($sformatf("latency_edge%0d_count", e), int'(pulse_counts), 0);
        end
        @(posedge clk);
        #1 chk("latency_edge4_count", int'(pulse_counts), 1);
        chk("latency_edge4_strobe", int'(pulse_strobe), 1);
        trig_in = 1'b0;
        repeat (10) @(posedge clk);
        chk("latency_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_saturate();
        test_restart_coincident();
        test_capture_gate();
        test_async_reset();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
